lfsr_prng_stream: RTL
=====================

# lfsr_prng_stream

Parametrised Fibonacci LFSR pseudo-random generator with a valid/ready output stream, runtime seed loading and optional period tracking. It is the general-width successor to the fixed 8-bit free-running PRNG. It feeds stimulus and dataset-generation pipelines that may stall, so the sequence advances only when a word is consumed.

## Interface
- `WIDTH`, 8: LFSR and output width. Must be ≥ 3.
- `TAPS`, 8'hB8: feedback mask. Bit i set means state[i] joins the XOR. Bit WIDTH-1 must be set.
- `SEED`, 1: reset and fallback seed. Must be nonzero and fit in WIDTH bits.

- `clk` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: run request. Level-sensitive.
- `seed_valid` in 1: load `seed_data` this cycle.
- `seed_data` in WIDTH: new seed value.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_ready` in 1: the consumer accepts the word.
- `out_data` out WIDTH: current LFSR state, driven directly from the register.
- `seed_err` out 1: one-cycle pulse when a zero seed is replaced by `SEED`.
- `wrap` out 1: one-cycle pulse when the sequence returns to its start value. Active only with the macro.
- `step_cnt` out WIDTH: steps since the last seed load or reset. Active only with the macro.

## Operation
- Next-state function: `next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}`. This is a left shift with the feedback bit entering at bit 0.
- `start` register: the value the current sequence began from, either `SEED` or the last loaded seed.
- FSM states are IDLE and RUN.
- `out_valid` is 1 only in RUN.
- In IDLE, `en=1` moves the FSM to RUN on the next cycle. `en=0` keeps it in IDLE.
- In RUN, a handshake (`out_valid & out_ready`) steps the LFSR: `lfsr <= next`.
- If RUN has no handshake, `lfsr` holds and `out_data` stays stable. This stability is mandatory under back-pressure.
- In RUN with `en=0`, the FSM moves to IDLE on the next cycle. A handshake in that same cycle still steps the LFSR.
- Seed load, in any state, has priority over stepping and over `en`:
  - `lfsr <= (seed_data==0) ? SEED : seed_data`, and `start` takes the same value.
  - The FSM goes to IDLE.
  - `step_cnt` goes to 0.
  - `seed_err` pulses on the next cycle if `seed_data` was zero.
- Handshake coinciding with a seed load: the consumer keeps the old word, and that step is discarded.
- The all-zero state is unreachable. The seed path never loads zero and the reset value is `SEED`.
- For WIDTH=8 and TAPS=8'hB8 the polynomial is x^8+x^6+x^5+x^4+1, which is maximal with period 255.

## Timing
- Reset values:
  - `lfsr = SEED`, `start = SEED`, FSM in IDLE.
  - `out_valid = 0`, `out_data = SEED`.
  - `seed_err = 0`, `wrap = 0`, `step_cnt = 0`.
- Reset asserted mid-stream overrides everything on the next edge.
- Latency, `en` rising in IDLE to the first valid word: 1 cycle.
- Latency from a seed load accepted at edge N:
  - `out_valid` is 0 for the cycle after edge N, then returns 1 for the cycle after edge N+1, provided `en=1`.
  - `out_data` equals the new seed from edge N onward.
- Throughput: one word per cycle while `out_ready` is held high in RUN.
- `seed_err` and `wrap` are registered single-cycle pulses.

## Configuration
- Macro: `LFSR_PRNG_PERIOD_EN`.
- Defined:
  - `step_cnt` increments on every step and wraps modulo 2^WIDTH.
  - `wrap` pulses on the cycle after a step whose `next == start`. `step_cnt` is cleared to 0 on that same step.
- Undefined: `wrap` and `step_cnt` are tied to 0, and no counter or `start` compare logic is built.

## Test plan
- Reset, then `en=1` and `out_ready=1` with defaults:
  - `out_valid` rises 1 cycle after `en` rises.
  - Accepted words are 01, 02, 04, 08, 11, 23, 47.
- Back-pressure: drop `out_ready` for 5 cycles while `out_data=08`. `out_data` must hold 08 with `out_valid=1`, then resume with 11.
- Zero seed: `seed_valid=1` with `seed_data=00`.
  - `seed_err` pulses once.
  - `out_data=01`.
  - `out_valid` is low for one cycle, then high.
- Seed load together with a handshake at `out_data=23`, seed = 5A:
  - The consumer receives 23.
  - The next accepted word is 5A, and 47 never appears.
- With `LFSR_PRNG_PERIOD_EN`, free-run from seed 01:
  - `wrap` pulses exactly once after 255 steps and `step_cnt` returns to 0.
  - Without the macro, `wrap` stays 0.
- `reset` asserted in RUN mid-stream: on the next cycle `out_valid=0` and `out_data=01`, and the sequence restarts from 01.

Source files
------------

// File: rtl/lfsr_prng_stream.sv
// Fibonacci LFSR PRNG on a valid/ready stream; 1 cycle en->valid; out_data holds under back-pressure.
// `define LFSR_PRNG_PERIOD_EN to build the step counter and the wrap-to-start pulse.
module lfsr_prng_stream #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             seed_err,
  output logic             wrap,
  output logic [WIDTH-1:0] step_cnt
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_eff;
  logic             seed_zero;
  logic             hs;

  assign lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign seed_zero = (seed_data == '0);
  // A zero seed would lock the LFSR, so it is replaced by the fallback seed.
  assign seed_eff  = seed_zero ? SEED : seed_data;
  assign hs        = out_valid & out_ready;
  assign out_data  = lfsr;

`ifdef LFSR_PRNG_PERIOD_EN
  logic [WIDTH-1:0] start;

  always_ff @(posedge clk) begin
    if (reset) begin
      start    <= SEED;
      step_cnt <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (seed_valid) begin
        start    <= seed_eff;
        step_cnt <= '0;
      end else if (state == RUN && hs) begin
        if (lfsr_next == start) begin
          step_cnt <= '0;
          wrap     <= 1'b1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign wrap     = 1'b0;
  assign step_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      out_valid <= 1'b0;
      seed_err  <= 1'b0;
    end else begin
      seed_err <= 1'b0;
      if (seed_valid) begin
        // Seed load wins over stepping; a coincident handshake's step is dropped.
        lfsr      <= seed_eff;
        state     <= IDLE;
        out_valid <= 1'b0;
        seed_err  <= seed_zero;
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              state     <= RUN;
              out_valid <= 1'b1;
            end
          end
          RUN: begin
            if (hs) lfsr <= lfsr_next;
            if (!en) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
